// File: rtl/pipe_pkg.sv
// Shared types and field widths for the pipeline stage registers (ID/EX, EX/MEM, MEM/WB).
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_t;

    // Control value of a bubble: no RegWrite, no MemWrite, no branch.
    localparam int unsigned CTRL_BUBBLE = 0;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ALUCTRL_W  = 4;
    localparam int unsigned FLAG_W     = 8;

    typedef struct packed {
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_write;
        logic                 branch;
        logic                 jump;
        logic                 mem_to_reg;
        logic                 alu_src;
        logic                 reg_dst;
        logic [ALUCTRL_W-1:0] alu_ctrl;
    } idex_ctrl_t;

    localparam int unsigned IDEX_CTRL_W  = FLAG_W + ALUCTRL_W;
    localparam int unsigned IDEX_DATA_W  = INSTR_W + 5 * XLEN + REG_ADDR_W;
    localparam int unsigned EXMEM_DATA_W = 3 * XLEN + REG_ADDR_W;
    localparam int unsigned MEMWB_DATA_W = 2 * XLEN + REG_ADDR_W;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle between two pipeline stages, upstream and downstream sides.
interface pipe_stage_skid_if #(
    parameter int unsigned CTRL_W = 12,
    parameter int unsigned DATA_W = 197
);
    import pipe_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );

endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter for performance events; holds at all-ones instead of wrapping.
module pipe_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);
    import pipe_pkg::*;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, optional skid entry, flush-to-bubble
// and a saturating bubble-cycle counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = IDEX_CTRL_W,
    parameter int unsigned DATA_W = IDEX_DATA_W,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    pipe_stage_skid_if.slave bus,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam bit HAS_SKID = (SKID != 0);

    pipe_state_t       state_q;
    pipe_state_t       state_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] main_data_q;
    logic [DATA_W-1:0] main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;
    logic              skid_load;
    logic              in_ready_c;
    logic              acc;
    logic              drn;

    // Next-state logic; main_ctrl is forced to the bubble value whenever the stage goes empty.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_load   = 1'b0;

        if (HAS_SKID) begin
            in_ready_c = !reset && !flush && (state_q != ST_SKID);
        end else begin
            in_ready_c = !reset && !flush && (!out_valid_q || bus.out_ready);
        end
        acc = bus.in_valid && in_ready_c;
        drn = out_valid_q && bus.out_ready;

        if (flush) begin
            state_d     = ST_EMPTY;
            out_valid_d = 1'b0;
            main_ctrl_d = CTRL_W'(CTRL_BUBBLE);
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        main_ctrl_d = bus.in_ctrl;
                        main_data_d = bus.in_data;
                        out_valid_d = 1'b1;
                        state_d     = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (acc && drn) begin
                        main_ctrl_d = bus.in_ctrl;
                        main_data_d = bus.in_data;
                    end else if (acc && HAS_SKID) begin
                        skid_load = 1'b1;
                        state_d   = ST_SKID;
                    end else if (drn) begin
                        out_valid_d = 1'b0;
                        main_ctrl_d = CTRL_W'(CTRL_BUBBLE);
                        state_d     = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (drn) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        state_d     = ST_FULL;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    out_valid_d = 1'b0;
                    main_ctrl_d = CTRL_W'(CTRL_BUBBLE);
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            main_ctrl_q <= '0;
            main_data_q <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
        end
    end

    // Spare entry holds the younger beat while the output is stalled.
    if (HAS_SKID) begin : g_skid
        always_ff @(posedge clock) begin
            if (reset) begin
                skid_ctrl_q <= '0;
                skid_data_q <= '0;
            end else if (skid_load) begin
                skid_ctrl_q <= bus.in_ctrl;
                skid_data_q <= bus.in_data;
            end
        end
    end else begin : g_no_skid
        assign skid_ctrl_q = '0;
        assign skid_data_q = '0;
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ctrl  = main_ctrl_q;
    assign bus.out_data  = main_data_q;

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (bus.out_ready && !out_valid_q),
        .clear (1'b0),
        .count (bubble_cnt)
    );

endmodule
